// File: rtl/snn_pkg.sv
// Shared definitions for the SNN neuron pipeline: FP32 field layout,
// common FP32 constants and the spike generator FSM state encoding.
package snn_pkg;

    // FP32 field layout
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    // Common FP32 values
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // Spike generator FSM states
    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        EMIT
    } state_e;

endpackage

// File: rtl/spike_generator_if.sv
// Handshake bundle for the spike generator: decayed-potential input,
// potential writeback and spike event output.
interface spike_generator_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_potential;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_potential;

    logic              spike_valid;
    logic              spike_ready;
    logic [ADDR_W-1:0] spike_addr;

    // Upstream decay stage and downstream consumers
    modport master (
        output in_valid, in_addr, in_potential, spike_ready,
        input  in_ready, wb_valid, wb_addr, wb_potential, spike_valid, spike_addr
    );

    // Spike generator side
    modport slave (
        input  in_valid, in_addr, in_potential, spike_ready,
        output in_ready, wb_valid, wb_addr, wb_potential, spike_valid, spike_addr
    );

endinterface

// File: rtl/fp32_ge_compare.sv
// Combinational FP32 a >= b compare in sign-magnitude form.
// +0 and -0 compare equal; any NaN operand gives unordered=1 and ge=0.
module fp32_ge_compare
    import snn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ge,
    output logic        unordered
);

    logic        a_nan;
    logic        b_nan;
    logic [30:0] a_mag;
    logic [30:0] b_mag;

    // Classify operands and order them by sign, then magnitude
    always_comb begin
        a_nan = (a[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (a[EXP_LSB-1:0] != '0);
        b_nan = (b[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (b[EXP_LSB-1:0] != '0);
        a_mag = a[EXP_MSB:0];
        b_mag = b[EXP_MSB:0];
        unordered = a_nan || b_nan;
        ge = 1'b0;
        if (unordered) begin
            ge = 1'b0;
        end else if ((a_mag == '0) && (b_mag == '0)) begin
            ge = 1'b1;
        end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            ge = !a[SIGN_BIT];
        end else if (a[SIGN_BIT]) begin
            // Both negative: larger magnitude is the smaller value
            ge = (a_mag <= b_mag);
        end else begin
            ge = (a_mag >= b_mag);
        end
    end

endmodule

// File: rtl/spike_generator.sv
// Spike generator: compares each decayed membrane potential against the
// firing threshold, writes back the next potential, emits spike events and
// tracks per-neuron refractory periods in timesteps.
// Optional per-neuron spike counters with a read port: define SPIKE_COUNT_EN.
module spike_generator
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 20,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned REFR_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [31:0]       cfg_threshold,
    input  logic [31:0]       cfg_v_reset,
    input  logic [REFR_W-1:0] cfg_refractory,
    input  logic              timestep,
    spike_generator_if.slave  bus
`ifdef SPIKE_COUNT_EN
    ,
    input  logic [ADDR_W-1:0] cnt_addr,
    output logic [15:0]       cnt_value
`endif
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [ADDR_W-1:0] NUM_ADDR = ADDR_W'(NUM_NEURONS);

    state_e              state_q;
    logic                in_ready_q;
    logic                wb_valid_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [31:0]         wb_pot_q;
    logic                spike_valid_q;
    logic [ADDR_W-1:0]   spike_addr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                fire_q;
    logic [31:0]         thr_q;
    logic [31:0]         vres_q;
    logic [REFR_W-1:0]   refr_q;
    logic [REFR_W-1:0]   refr_cnt_q [NUM_NEURONS];

    logic [31:0]         thr_eff;
    logic [31:0]         vres_eff;
    logic [IDX_W-1:0]    in_idx;
    logic [IDX_W-1:0]    ld_idx;
    logic                in_range;
    logic                refr_busy;
    logic                ge;
    logic                unordered;
    logic                fire;
    logic                refr_load;

    // A same-cycle config write applies to the input being accepted
    always_comb begin
        thr_eff   = cfg_we ? cfg_threshold : thr_q;
        vres_eff  = cfg_we ? cfg_v_reset : vres_q;
        in_idx    = bus.in_addr[IDX_W-1:0];
        ld_idx    = addr_q[IDX_W-1:0];
        in_range  = (bus.in_addr < NUM_ADDR);
        refr_busy = in_range && (refr_cnt_q[in_idx] != '0);
        fire      = !refr_busy && ge && !unordered;
        refr_load = (state_q == EVAL) && fire_q;
    end

    fp32_ge_compare u_thr_cmp (
        .a         (bus.in_potential),
        .b         (thr_eff),
        .ge        (ge),
        .unordered (unordered)
    );

    // Control FSM with registered handshake and writeback outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_pot_q      <= '0;
            spike_valid_q <= 1'b0;
            spike_addr_q  <= '0;
            addr_q        <= '0;
            fire_q        <= 1'b0;
            thr_q         <= FP32_ONE;
            vres_q        <= FP32_ZERO;
            refr_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (cfg_we) begin
                        thr_q  <= cfg_threshold;
                        vres_q <= cfg_v_reset;
                        refr_q <= cfg_refractory;
                    end
                    // Out-of-range addresses are consumed without any effect
                    if (bus.in_valid && in_ready_q && in_range) begin
                        state_q    <= EVAL;
                        in_ready_q <= 1'b0;
                        addr_q     <= bus.in_addr;
                        fire_q     <= fire;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= bus.in_addr;
                        // Refractory neurons stay clamped at v_reset
                        wb_pot_q   <= (fire || refr_busy) ? vres_eff : bus.in_potential;
                    end
                end
                EVAL: begin
                    wb_valid_q <= 1'b0;
                    if (fire_q) begin
                        state_q       <= EMIT;
                        spike_valid_q <= 1'b1;
                        spike_addr_q  <= addr_q;
                    end else begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.spike_ready) begin
                        state_q       <= IDLE;
                        spike_valid_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Refractory counters: a load on fire beats a coincident timestep decrement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                refr_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                if (refr_load && (ld_idx == IDX_W'(i))) begin
                    refr_cnt_q[i] <= refr_q;
                end else if (timestep && (refr_cnt_q[i] != '0)) begin
                    refr_cnt_q[i] <= refr_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.wb_potential = wb_pot_q;
    assign bus.spike_valid  = spike_valid_q;
    assign bus.spike_addr   = spike_addr_q;

`ifdef SPIKE_COUNT_EN
    logic [15:0]      spk_cnt_q [NUM_NEURONS];
    logic [15:0]      cnt_value_q;
    logic [IDX_W-1:0] spk_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             spk_hs;
    logic             rd_in_range;

    always_comb begin
        spk_idx     = spike_addr_q[IDX_W-1:0];
        rd_idx      = cnt_addr[IDX_W-1:0];
        spk_hs      = (state_q == EMIT) && spike_valid_q && bus.spike_ready;
        rd_in_range = (cnt_addr < NUM_ADDR);
    end

    // Saturating per-neuron spike counts, bumped on each spike handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                spk_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                if (spk_hs && (spk_idx == IDX_W'(i)) && (spk_cnt_q[i] != 16'hFFFF)) begin
                    spk_cnt_q[i] <= spk_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Registered count read port; out-of-range addresses read as zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_value_q <= '0;
        end else begin
            cnt_value_q <= rd_in_range ? spk_cnt_q[rd_idx] : 16'd0;
        end
    end

    assign cnt_value = cnt_value_q;
`endif

endmodule

// File: tb/tb_spike_generator.sv
// Self-checking bench for spike_generator: table of single-shot evaluations
// plus directed sequences for reset, spike hold, refractory and counters.
module tb_spike_generator;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [31:0] cfg_threshold;
    logic [31:0] cfg_v_reset;
    logic [3:0]  cfg_refractory;
    logic        timestep;
`ifdef SPIKE_COUNT_EN
    logic [11:0] cnt_addr;
    logic [15:0] cnt_value;
`endif

    int tests;
    int fails;

    spike_generator_if #(.ADDR_W(12)) bus ();

    spike_generator #(
        .NUM_NEURONS (20),
        .ADDR_W      (12),
        .REFR_W      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_threshold  (cfg_threshold),
        .cfg_v_reset    (cfg_v_reset),
        .cfg_refractory (cfg_refractory),
        .timestep       (timestep),
        .bus            (bus)
`ifdef SPIKE_COUNT_EN
        ,
        .cnt_addr       (cnt_addr),
        .cnt_value      (cnt_value)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] pot;
        logic [31:0] thr;
        logic [31:0] vres;
        bit          exp_wb;
        bit          exp_fire;
        logic [31:0] exp_pot;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: in_ready timeout, got %b, expected 1", name, bus.in_ready);
        end
    endtask

    // One input transaction; hold = cycles spike_ready stays low while spiking
    task automatic send(input bit use_cfg, input logic [11:0] addr, input logic [31:0] pot,
                        input logic [31:0] thr, input logic [31:0] vres,
                        input logic [3:0] refr, input bit exp_wb, input bit exp_fire,
                        input logic [31:0] exp_pot, input int hold, input bit ts_eval,
                        input string name);
        wait_ready(name);
        cfg_we            = use_cfg;
        cfg_threshold     = thr;
        cfg_v_reset       = vres;
        cfg_refractory    = refr;
        bus.in_valid      = 1'b1;
        bus.in_addr       = addr;
        bus.in_potential  = pot;
        tick();
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        chk({name, " wb_valid"}, 32'(bus.wb_valid), 32'(exp_wb));
        if (exp_wb) begin
            chk({name, " wb_potential"}, bus.wb_potential, exp_pot);
            chk({name, " wb_addr"}, 32'(bus.wb_addr), 32'(addr));
        end
        timestep = ts_eval;
        tick();
        timestep = 1'b0;
        chk({name, " spike_valid"}, 32'(bus.spike_valid), 32'(exp_fire));
        if (exp_fire) begin
            chk({name, " spike_addr"}, 32'(bus.spike_addr), 32'(addr));
            for (int k = 0; k < hold; k++) begin
                tick();
                chk({name, " spike held"}, 32'(bus.spike_valid), 32'd1);
                chk({name, " spike_addr held"}, 32'(bus.spike_addr), 32'(addr));
                chk({name, " in_ready in EMIT"}, 32'(bus.in_ready), 32'd0);
            end
            bus.spike_ready = 1'b1;
            tick();
            bus.spike_ready = 1'b0;
            chk({name, " spike dropped"}, 32'(bus.spike_valid), 32'd0);
        end
        chk({name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic pulse_timestep();
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{12'd3,  32'h41DEB852, 32'h3F800000, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
        vecs[1]  = '{12'd3,  32'h41DEB852, 32'h41F00000, 32'h3F000000, 1'b1, 1'b0, 32'h41DEB852};
        vecs[2]  = '{12'd4,  32'h80000000, 32'h00000000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[3]  = '{12'd4,  32'h7FC00000, 32'h3F800000, 32'h3F000000, 1'b1, 1'b0, 32'h7FC00000};
        vecs[4]  = '{12'd6,  32'h7F800000, 32'h3F800000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[5]  = '{12'd6,  32'hC0000000, 32'hBF800000, 32'h3F000000, 1'b1, 1'b0, 32'hC0000000};
        vecs[6]  = '{12'd6,  32'hBF800000, 32'hC0000000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[7]  = '{12'd7,  32'h3F800000, 32'h3F800000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[8]  = '{12'd7,  32'h3F7FFFFF, 32'h3F800000, 32'h3F000000, 1'b1, 1'b0, 32'h3F7FFFFF};
        vecs[9]  = '{12'd8,  32'h3F800000, 32'h7FC00000, 32'h3F000000, 1'b1, 1'b0, 32'h3F800000};
        vecs[10] = '{12'd9,  32'h00000000, 32'h80000000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[11] = '{12'd9,  32'h00800000, 32'h80800000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[12] = '{12'd19, 32'h40000000, 32'h3F800000, 32'h3F000000, 1'b1, 1'b1, 32'h3F000000};
        vecs[13] = '{12'd20, 32'h40000000, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 32'h00000000};
        vecs[14] = '{12'd25, 32'h42480000, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 32'h00000000};
        vecs[15] = '{12'd2,  32'hFF800000, 32'h3F800000, 32'h3F000000, 1'b1, 1'b0, 32'hFF800000};
        vecs[16] = '{12'd2,  32'h7F800001, 32'hFF800000, 32'h3F000000, 1'b1, 1'b0, 32'h7F800001};

        rst_n            = 1'b0;
        cfg_we           = 1'b0;
        cfg_threshold    = '0;
        cfg_v_reset      = '0;
        cfg_refractory   = '0;
        timestep         = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_addr      = '0;
        bus.in_potential = '0;
        bus.spike_ready  = 1'b0;
`ifdef SPIKE_COUNT_EN
        cnt_addr = '0;
`endif

        // Reset state
        tick();
        tick();
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("reset wb_potential", bus.wb_potential, 32'd0);
        chk("reset spike_valid", 32'(bus.spike_valid), 32'd0);
        chk("reset spike_addr", 32'(bus.spike_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first idle in_ready", 32'(bus.in_ready), 32'd1);

        // Default threshold 1.0 and v_reset 0, spike held through backpressure
        send(1'b0, 12'd3, 32'h41DEB852, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 32'h0, 3, 1'b0,
             "default_thr");

        // Table: config written in the same cycle as the input it applies to
        for (int i = 0; i < 17; i++) begin
            send(1'b1, vecs[i].addr, vecs[i].pot, vecs[i].thr, vecs[i].vres, 4'd0,
                 vecs[i].exp_wb, vecs[i].exp_fire, vecs[i].exp_pot, 0, 1'b0,
                 $sformatf("vec%0d", i));
        end

        // Refractory = 2 on neuron 5
        send(1'b1, 12'd5, 32'h42480000, 32'h3F800000, 32'h3F000000, 4'd2, 1'b1, 1'b1,
             32'h3F000000, 0, 1'b0, "refr_fire");
        send(1'b0, 12'd5, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0,
             32'h3F000000, 0, 1'b0, "refr_block0");
        pulse_timestep();
        send(1'b0, 12'd5, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0,
             32'h3F000000, 0, 1'b0, "refr_block1");
        pulse_timestep();
        // Fires again; timestep during EVAL must not beat the counter load
        send(1'b0, 12'd5, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1,
             32'h3F000000, 0, 1'b1, "refr_release");
        pulse_timestep();
        send(1'b0, 12'd5, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0,
             32'h3F000000, 0, 1'b0, "refr_load_wins");

        // Reset during EMIT abandons the spike and clears counters and config
        wait_ready("rst_emit");
        cfg_we           = 1'b1;
        cfg_threshold    = 32'h3F800000;
        cfg_v_reset      = 32'h40000000;
        cfg_refractory   = 4'd3;
        bus.in_valid     = 1'b1;
        bus.in_addr      = 12'd10;
        bus.in_potential = 32'h42480000;
        tick();
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        tick();
        chk("rst_emit spike before reset", 32'(bus.spike_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_emit spike_valid", 32'(bus.spike_valid), 32'd0);
        chk("rst_emit wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_emit in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_emit ready after", 32'(bus.in_ready), 32'd1);
        send(1'b0, 12'd10, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1,
             32'h00000000, 0, 1'b0, "post_rst_n10");
        send(1'b0, 12'd5, 32'h42480000, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1,
             32'h00000000, 0, 1'b0, "post_rst_n5");

`ifdef SPIKE_COUNT_EN
        for (int r = 0; r < 3; r++) begin
            send(1'b1, 12'd7, 32'h3F800000, 32'h3F800000, 32'h0, 4'd0, 1'b1, 1'b1,
                 32'h0, 0, 1'b0, "cnt_fire");
        end
        cnt_addr = 12'd7;
        tick();
        chk("cnt_value n7", 32'(cnt_value), 32'd3);
        cnt_addr = 12'd25;
        tick();
        chk("cnt_value oor", 32'(cnt_value), 32'd0);
        cnt_addr = 12'd10;
        tick();
        chk("cnt_value n10", 32'(cnt_value), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
